// File: rtl/delta_sigma_pw_modulator.sv
// Error-feedback requantiser feeding a single/dual-slope PWM generator.
// Defining DS_SECOND_ORDER_EN selects second-order noise shaping; the default build is first order.

module delta_sigma_quantiser #(
   parameter int IN_BITS   = 16,
   parameter int FRAC_BITS = 8,
   parameter int PWM_BITS  = 9
) (
   input  logic [IN_BITS-1:0]          u,
   input  logic signed [FRAC_BITS-1:0] err0,
   input  logic signed [FRAC_BITS-1:0] err1,
   input  logic [PWM_BITS-1:0]         limit,
   output logic [PWM_BITS-1:0]         y_next,
   output logic signed [FRAC_BITS-1:0] err_next
);
   localparam int VW = IN_BITS + 2;
   localparam logic signed [VW-1:0] HALF  = VW'(2 ** (FRAC_BITS - 1));
   localparam logic signed [VW-1:0] E_MAX = HALF - VW'(1);
   localparam logic signed [VW-1:0] E_MIN = -HALF;

   logic signed [VW-1:0] u_ext, v, q, lim, y_wide, resid;

   assign u_ext = signed'(VW'(u));
   assign lim   = signed'(VW'(limit));

`ifdef DS_SECOND_ORDER_EN
   assign v = u_ext + (VW'(err0) <<< 1) - VW'(err1);
`else
   assign v = u_ext + VW'(err0);
`endif

   // round half up, then clip into the duty range so y can never overflow
   assign q = (v + HALF) >>> FRAC_BITS;

   always_comb begin
      y_wide = q;
      if (q < 0)
         y_wide = '0;
      else if (q > lim)
         y_wide = lim;
   end

   assign y_next = PWM_BITS'(y_wide);
   assign resid  = v - (y_wide <<< FRAC_BITS);

   always_comb begin
      err_next = FRAC_BITS'(resid);
      if (resid > E_MAX)
         err_next = FRAC_BITS'(E_MAX);
      else if (resid < E_MIN)
         err_next = FRAC_BITS'(E_MIN);
   end
endmodule

// Counter direction states (dual slope only; single slope stays in DIR_UP)
//   state    | meaning
//   DIR_UP   | counting up from 0 towards the last value below M
//   DIR_DOWN | repeating the top value then counting back to 0
module delta_sigma_pw_modulator #(
   parameter int IN_BITS   = 16,
   parameter int FRAC_BITS = 8,
   parameter int PWM_BITS  = 9
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [IN_BITS-1:0]  u,
   input  logic                dual_slope_en,
   input  logic                double_slope_en,
   input  logic [PWM_BITS-1:0] compare_max,
   output logic                pulse_done,
   output logic                pwm_out
);
   localparam logic [0:0] DIR_UP   = 1'b0;
   localparam logic [0:0] DIR_DOWN = 1'b1;

   logic [PWM_BITS-1:0] k, k_next, m_lat, m_eff, y, y_eff, y_next;
   logic [PWM_BITS:0]   step, k_up, m_ext;
   logic [0:0]          dir, dir_next;
   logic                start, dual_lat, dbl_lat, dual_eff, dbl_eff, last;
   logic                y_valid, y_loaded;
   logic signed [FRAC_BITS-1:0] sreg [0:1];
   logic signed [FRAC_BITS-1:0] err_next;

   delta_sigma_quantiser #(
      .IN_BITS  (IN_BITS),
      .FRAC_BITS(FRAC_BITS),
      .PWM_BITS (PWM_BITS)
   ) ds_mod (
      .u       (u),
      .err0    (sreg[0]),
      .err1    (sreg[1]),
      .limit   (compare_max),
      .y_next  (y_next),
      .err_next(err_next)
   );

   // live configuration applies only in the first cycle of a period, latched copy afterwards
   assign m_eff    = start ? compare_max     : m_lat;
   assign dual_eff = start ? dual_slope_en   : dual_lat;
   assign dbl_eff  = start ? double_slope_en : dbl_lat;

   assign step  = dbl_eff ? (PWM_BITS+1)'(2) : (PWM_BITS+1)'(1);
   assign k_up  = {1'b0, k} + step;
   assign m_ext = {1'b0, m_eff};
   assign y_eff = (y > m_eff) ? m_eff : y;

   always_comb begin
      last     = 1'b0;
      k_next   = k;
      dir_next = dir;
      if (m_eff == '0) begin
         last     = 1'b1;
         k_next   = '0;
         dir_next = DIR_UP;
      end else if (!dual_eff) begin
         if (k_up > m_ext) begin
            last   = 1'b1;
            k_next = '0;
         end else begin
            k_next = k_up[PWM_BITS-1:0];
         end
      end else if (dir == DIR_UP) begin
         if (k_up >= m_ext)
            dir_next = DIR_DOWN;
         else
            k_next = k_up[PWM_BITS-1:0];
      end else begin
         if (k == '0) begin
            last     = 1'b1;
            dir_next = DIR_UP;
         end else begin
            k_next = k - step[PWM_BITS-1:0];
         end
      end
   end

   assign pulse_done = last & ~reset;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         k        <= '0;
         dir      <= DIR_UP;
         start    <= 1'b1;
         m_lat    <= '0;
         dual_lat <= 1'b0;
         dbl_lat  <= 1'b0;
         y        <= '0;
         y_valid  <= 1'b0;
         y_loaded <= 1'b0;
         sreg[0]  <= '0;
         sreg[1]  <= '0;
         pwm_out  <= 1'b0;
      end else begin
         k       <= k_next;
         dir     <= dir_next;
         start   <= last;
         y_valid <= last;
         if (start) begin
            m_lat    <= compare_max;
            dual_lat <= dual_slope_en;
            dbl_lat  <= double_slope_en;
         end
         if (last) begin
            y       <= y_next;
            sreg[1] <= sreg[0];
            sreg[0] <= err_next;
         end
         if (y_valid)
            y_loaded <= 1'b1;
         // output stays low until the first requantised sample has landed
         pwm_out <= (y_loaded | y_valid) & (k < y_eff);
      end
   end
endmodule

// File: tb/tb_delta_sigma_pw_modulator.sv
// Self-checking bench: per-period length and high-time checked against an arithmetic model
// of the requantiser and PWM duty rules.

module tb_delta_sigma_pw_modulator;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] u = '0;
   logic        dual_slope_en = 1'b0;
   logic        double_slope_en = 1'b0;
   logic [8:0]  compare_max = 9'd255;
   logic        pulse_done, pwm_out;

   int vectors = 0;
   int miscompares = 0;
   int ms0 = 0, ms1 = 0, my = 0;

   delta_sigma_pw_modulator dut (
      .clk            (clk),
      .reset          (reset),
      .u              (u),
      .dual_slope_en  (dual_slope_en),
      .double_slope_en(double_slope_en),
      .compare_max    (compare_max),
      .pulse_done     (pulse_done),
      .pwm_out        (pwm_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int ceil_div(input int a, input int b);
      return (a + b - 1) / b;
   endfunction

   task automatic model_update(input int uu, input int m);
      int v, q, yn, e;
`ifdef DS_SECOND_ORDER_EN
      v = uu + 2 * ms0 - ms1;
`else
      v = uu + ms0;
`endif
      q  = (v + 128) >>> 8;
      yn = (q < 0) ? 0 : ((q > m) ? m : q);
      e  = v - yn * 256;
      if (e > 127)  e = 127;
      if (e < -128) e = -128;
      ms1 = ms0;
      ms0 = e;
      my  = yn;
   endtask

   // Called with the DUT at the first cycle of a period and inputs already set for it.
   task automatic run_period(input string tag, input int chg = -1, input int new_m = 0,
                             input bit new_dual = 1'b0, input bit new_dbl = 1'b0);
      int m, s, ye, exp_len, exp_high, high, c;
      bit dual, found;
      m    = int'(compare_max);
      dual = dual_slope_en;
      s    = double_slope_en ? 2 : 1;
      ye   = (my > m) ? m : my;
      if (dual) begin
         exp_len  = (m == 0) ? 1 : 2 * ceil_div(m, s);
         exp_high = (m == 0) ? 0 : 2 * ceil_div(ye, s);
      end else begin
         exp_len  = m / s + 1;
         exp_high = ceil_div(ye, s);
      end
      high  = 0;
      c     = 0;
      found = 1'b0;
      #1;
      while (!found && c < 1100) begin
         if (pulse_done) begin
            found = 1'b1;
            model_update(int'(u), int'(compare_max));
         end else begin
            @(negedge clk);
            #1;
            c++;
            high += int'(pwm_out);
            if (c == chg) begin
               compare_max     = 9'(new_m);
               dual_slope_en   = new_dual;
               double_slope_en = new_dbl;
            end
         end
      end
      check({tag, " period"}, found ? c + 1 : -1, exp_len);
      @(negedge clk);
      #1;
      high += int'(pwm_out);
      check({tag, " high"}, high, exp_high);
   endtask

   initial begin
      compare_max = 9'd0;
      repeat (3) @(negedge clk);
      #1;
      check("reset pulse_done", int'(pulse_done), 0);
      check("reset pwm_out", int'(pwm_out), 0);

      @(negedge clk);
      compare_max = 9'd255;
      u = 16'h0000;
      reset = 1'b0;
      run_period("idle0");
      run_period("idle1");

      u = 16'h8000;
      run_period("half0");
      run_period("half1");
      run_period("half2");

      // abort mid-period while the pulse is high
      repeat (59) @(negedge clk);
      #1;
      check("pre-reset pwm", int'(pwm_out), (59 < ((my > 255) ? 255 : my)) ? 1 : 0);
      reset = 1'b1;
      #1;
      check("async reset pwm", int'(pwm_out), 0);
      check("async reset pd", int'(pulse_done), 0);
      ms0 = 0;
      ms1 = 0;
      my  = 0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      run_period("post-reset");

      u = 16'h8080;
      for (int i = 0; i < 4; i++) run_period("frac");

      dual_slope_en = 1'b1;
      u = 16'h4000;
      for (int i = 0; i < 3; i++) run_period("dual");

      dual_slope_en = 1'b0;
      double_slope_en = 1'b1;
      u = 16'hFF80;
      for (int i = 0; i < 3; i++) run_period("dbl clip");
      u = 16'hFF00;
      run_period("dbl full");

      compare_max = 9'd0;
      for (int i = 0; i < 4; i++) run_period("m0");
      dual_slope_en = 1'b1;
      run_period("m0 dual");

      dual_slope_en = 1'b0;
      double_slope_en = 1'b0;
      compare_max = 9'd100;
      u = 16'h4000;
      run_period("pre-chg");
      run_period("mode chg", 30, 200, 1'b1, 1'b1);
      run_period("post chg");

      for (int i = 0; i < 50; i++) begin
         u = 16'($urandom_range(0, 65535));
         case ($urandom_range(0, 3))
            0:       compare_max = 9'($urandom_range(0, 3));
            1:       compare_max = 9'($urandom_range(0, 63));
            default: compare_max = 9'($urandom_range(0, 511));
         endcase
         dual_slope_en   = 1'($urandom_range(0, 1));
         double_slope_en = 1'($urandom_range(0, 1));
         run_period("rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
